// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter: state encoding
// and the rotating-priority search.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } arb_state_t;

    // First set request index, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] ptr_v);
        logic [1:0] idx_s;
        logic [1:0] pick_s;
        logic       found_s;
        pick_s  = ptr_v;
        found_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx_s = ptr_v + 2'(i);
            if (!found_s && req_v[idx_s]) begin
                pick_s  = idx_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        return pick_s;
    endfunction

endpackage

// File: rtl/decoder2to4.sv
// 2-to-4 line decoder with enable; all outputs low while disabled.
module decoder2to4 (
    input  logic A,
    input  logic B,
    input  logic en,
    output logic Y0,
    output logic Y1,
    output logic Y2,
    output logic Y3
);

    // One-hot decode of {A,B}, gated by the enable.
    always_comb begin
        {Y3, Y2, Y1, Y0} = 4'b0000;
        if (en) begin
            case ({A, B})
                2'b00:   Y0 = 1'b1;
                2'b01:   Y1 = 1'b1;
                2'b10:   Y2 = 1'b1;
                2'b11:   Y3 = 1'b1;
                default: {Y3, Y2, Y1, Y0} = 4'b0000;
            endcase
        end else begin
            {Y3, Y2, Y1, Y0} = 4'b0000;
        end
    end

endmodule

// File: rtl/arb_rr4.sv
// Round-robin arbiter that owns the 2-to-4 decoder select/enable; one grant at a
// time, bounded hold of MAX_HOLD cycles, and a mandatory dead cycle between grants.
module arb_rr4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic       A,
    output logic       B,
    output logic       en,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    // Next-state logic: arbitrate from IDLE/GAP, hold or release in GRANT.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (|req) begin
                    sel_d   = rr_pick(req, ptr_q);
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!req[sel_q]) begin
                    state_d = GAP;
                    ptr_d   = sel_q + 2'd1;
                end else if (cnt_q == HOLD_LAST) begin
                    // Owner still asking at the hold limit: force release.
                    state_d   = GAP;
                    ptr_d     = sel_q + 2'd1;
                    timeout_d = 1'b1;
                end else begin
                    state_d = GRANT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        en_d   = (state_d == GRANT);
        busy_d = (state_d != IDLE);
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            sel_q     <= 2'd0;
            cnt_q     <= {CNT_W{1'b0}};
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign A       = sel_q[1];
    assign B       = sel_q[0];
    assign en      = en_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

    decoder2to4 u_dec (
        .A  (sel_q[1]),
        .B  (sel_q[0]),
        .en (en_q),
        .Y0 (gnt[0]),
        .Y1 (gnt[1]),
        .Y2 (gnt[2]),
        .Y3 (gnt[3])
    );

endmodule

// File: tb/tb_arb_rr4.sv
// Directed bench for arb_rr4: one instance with MAX_HOLD=4, one with MAX_HOLD=2.
module tb_arb_rr4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req4, req2;
    logic       a4, b4, en4, busy4, to4;
    logic [3:0] gnt4;
    logic       a2, b2, en2, busy2, to2;
    logic [3:0] gnt2;

    int n_cmp;
    int n_bad;

    logic [3:0] rr_g  [13];
    logic       rr_to [13];

    arb_rr4 #(.MAX_HOLD(4), .CNT_W(8)) u4 (
        .clk(clk), .rst_n(rst_n), .req(req4),
        .A(a4), .B(b4), .en(en4), .gnt(gnt4), .busy(busy4), .timeout(to4)
    );

    arb_rr4 #(.MAX_HOLD(2), .CNT_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .req(req2),
        .A(a2), .B(b2), .en(en2), .gnt(gnt2), .busy(busy2), .timeout(to2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rr_g  = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                  4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        rr_to = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        rst_n = 1'b0;
        req4  = 4'b0000;
        req2  = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_out4", {busy4, to4, gnt4}, 6'b000000);
        chk("reset_sel4", {3'b000, en4, a4, b4}, 6'b000000);
        chk("reset_out2", {busy2, to2, gnt2}, 6'b000000);

        // Single requester 1 for three cycles, then GAP, then IDLE.
        req4 = 4'b0010;
        tick(); chk("single_c1", {busy4, to4, gnt4}, 6'b100010);
        tick(); chk("single_c2", {busy4, to4, gnt4}, 6'b100010);
        tick(); chk("single_c3", {busy4, to4, gnt4}, 6'b100010);
        req4 = 4'b0000;
        tick(); chk("single_gap", {busy4, to4, gnt4}, 6'b100000);
        chk("single_gap_hold_sel", {3'b000, en4, a4, b4}, 6'b000001);
        tick(); chk("single_idle", {busy4, to4, gnt4}, 6'b000000);

        // Grant 3 completes (ptr wraps to 0), then 1001 must go to 0.
        req4 = 4'b1000;
        tick(); chk("wrap_g3", {busy4, to4, gnt4}, 6'b101000);
        req4 = 4'b0000;
        tick(); chk("wrap_gap", {busy4, to4, gnt4}, 6'b100000);
        req4 = 4'b1001;
        tick(); chk("wrap_next_g0", {busy4, to4, gnt4}, 6'b100001);
        req4 = 4'b0000;
        tick(); chk("wrap_gap2", {busy4, to4, gnt4}, 6'b100000);
        tick(); chk("wrap_idle", {busy4, to4, gnt4}, 6'b000000);

        // MAX_HOLD=4: drop on the fourth grant cycle is a normal release.
        req4 = 4'b0001;
        tick(); chk("tb4_c1", {busy4, to4, gnt4}, 6'b100001);
        tick(); chk("tb4_c2", {busy4, to4, gnt4}, 6'b100001);
        tick(); chk("tb4_c3", {busy4, to4, gnt4}, 6'b100001);
        tick(); chk("tb4_c4", {busy4, to4, gnt4}, 6'b100001);
        req4 = 4'b0000;
        tick(); chk("tb4_release_no_to", {busy4, to4, gnt4}, 6'b100000);

        // Held past the limit: forced release with timeout, re-grant after one GAP.
        req4 = 4'b0001;
        tick(); chk("tb5_c1", {busy4, to4, gnt4}, 6'b100001);
        tick(); chk("tb5_c2", {busy4, to4, gnt4}, 6'b100001);
        tick(); chk("tb5_c3", {busy4, to4, gnt4}, 6'b100001);
        tick(); chk("tb5_c4", {busy4, to4, gnt4}, 6'b100001);
        tick(); chk("tb5_timeout", {busy4, to4, gnt4}, 6'b110000);
        tick(); chk("tb5_regrant", {busy4, to4, gnt4}, 6'b100001);
        req4 = 4'b0000;
        tick(); chk("tb5_gap", {busy4, to4, gnt4}, 6'b100000);
        tick(); chk("tb5_idle", {busy4, to4, gnt4}, 6'b000000);

        // Non-owner requests ignored while 2 holds the grant; next grant to 3.
        req4 = 4'b0100;
        tick(); chk("nonown_c1", {busy4, to4, gnt4}, 6'b100100);
        req4 = 4'b1110;
        tick(); chk("nonown_c2", {busy4, to4, gnt4}, 6'b100100);
        tick(); chk("nonown_c3", {busy4, to4, gnt4}, 6'b100100);
        tick(); chk("nonown_c4", {busy4, to4, gnt4}, 6'b100100);
        tick(); chk("nonown_timeout", {busy4, to4, gnt4}, 6'b110000);
        tick(); chk("nonown_next_g3", {busy4, to4, gnt4}, 6'b101000);
        req4 = 4'b0000;
        tick();
        tick(); chk("nonown_idle", {busy4, to4, gnt4}, 6'b000000);

        // MAX_HOLD=2, all four requesting: 0,1,2,3,0 with a timeout per grant.
        req2 = 4'b1111;
        for (int i = 0; i < 13; i++) begin
            tick();
            chk($sformatf("rr_step%0d", i), {busy2, to2, gnt2}, {1'b1, rr_to[i], rr_g[i]});
        end
        req2 = 4'b0000;

        // Asynchronous reset in the middle of a grant.
        tick(); tick();
        req4 = 4'b0100;
        tick(); chk("rst_pre_grant", {busy4, to4, gnt4}, 6'b100100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_out", {busy4, to4, gnt4}, 6'b000000);
        chk("rst_async_sel", {3'b000, en4, a4, b4}, 6'b000000);
        tick();
        req4 = 4'b1000;
        tick();
        rst_n = 1'b1;
        chk("rst_held", {busy4, to4, gnt4}, 6'b000000);
        tick(); chk("rst_after_g3", {busy4, to4, gnt4}, 6'b101000);
        req4 = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
